// File: rtl/blood_sample_scheduler.sv
// Round-robin arbiter sharing one blood-type classifier among NUM_REQ
// stations. Optional throughput counters are enabled by BLOOD_STATS_EN.
//
// Ports:
//   clk, rst_n       clock, async active-low reset
//   req, req_type    per-station request and 3-bit blood type
//   ack, result      one-hot done pulse and classification result
//   class_type       drives classifier bloodType
//   class_result     classifier blood_output
//   busy, grant_id   not-IDLE flag, station being served
//   total_cnt        completed classifications (saturating)
//   accept_cnt       completed classifications with result=1
module blood_sample_scheduler #(
  parameter int NUM_REQ = 4,
  parameter int CNT_W   = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NUM_REQ-1:0]   req,
  input  logic [3*NUM_REQ-1:0] req_type,
  output logic [NUM_REQ-1:0]   ack,
  output logic                 result,
  output logic [2:0]           class_type,
  input  logic                 class_result,
  output logic                 busy,
  output logic [2:0]           grant_id,
  output logic [CNT_W-1:0]     total_cnt,
  output logic [CNT_W-1:0]     accept_cnt
);

  typedef enum logic [1:0] {
    IDLE,
    EVAL,
    DONE
  } state_t;

  state_t state, state_nxt;

  logic [2:0]  ptr;
  logic [2:0]  win;
  logic        win_vld;
  logic [3:0]  pos;
  logic [7:0]  req8;
  logic [23:0] type24;
  logic [2:0]  sel_type;
  logic [2:0]  ptr_nxt;
  logic [7:0]  ack8;

  // Padded copies let every select use a fixed 3-bit index.
  assign req8   = 8'(req);
  assign type24 = 24'(req_type);

  // Search upward from ptr with wrap; first hit wins.
  always_comb begin
    win     = '0;
    win_vld = 1'b0;
    pos     = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      pos = {1'b0, ptr} + 4'(i);
      if (pos >= 4'(NUM_REQ))
        pos = pos - 4'(NUM_REQ);
      if (!win_vld && req8[pos[2:0]]) begin
        win_vld = 1'b1;
        win     = pos[2:0];
      end
    end
  end

  always_comb begin
    sel_type = '0;
    for (int j = 0; j < NUM_REQ; j++) begin
      if (win == 3'(j))
        sel_type = type24[3*j +: 3];
    end
  end

  assign ptr_nxt = (grant_id == 3'(NUM_REQ-1))
                 ? 3'd0 : grant_id + 3'd1;
  assign ack8    = 8'd1 << grant_id;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      state <= IDLE;
    else
      state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (win_vld) state_nxt = EVAL;
      EVAL:    state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Output logic
  always_comb begin
    busy = (state != IDLE);
  end

  // Datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ack        <= '0;
      result     <= 1'b0;
      class_type <= 3'b000;
      grant_id   <= 3'd0;
      ptr        <= 3'd0;
    end else begin
      unique case (state)
        IDLE: begin
          if (win_vld) begin
            class_type <= sel_type;
            grant_id   <= win;
          end
        end
        EVAL: begin
          result <= class_result;
          ack    <= ack8[NUM_REQ-1:0];
          ptr    <= ptr_nxt;
        end
        DONE: begin
          ack <= '0;
        end
        default: begin
          ack <= '0;
        end
      endcase
    end
  end

`ifdef BLOOD_STATS_EN
  // Counters saturate instead of wrapping.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      total_cnt  <= '0;
      accept_cnt <= '0;
    end else if (state == EVAL) begin
      if (total_cnt != '1)
        total_cnt <= total_cnt + 1'b1;
      if (class_result && accept_cnt != '1)
        accept_cnt <= accept_cnt + 1'b1;
    end
  end
`else
  assign total_cnt  = '0;
  assign accept_cnt = '0;
`endif

endmodule

// File: tb/tb_blood_sample_scheduler.sv
// Directed bench for blood_sample_scheduler.
// Bench drives a LUT classifier model on class_type.
module tb_blood_sample_scheduler;

  localparam int N  = 4;
  localparam int CW = 2;
`ifdef BLOOD_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif
  localparam int CMAX = (1 << CW) - 1;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [N-1:0]  req;
  logic [3*N-1:0] req_type;
  logic [N-1:0]  ack;
  logic          result;
  logic [2:0]    class_type;
  logic          class_result;
  logic          busy;
  logic [2:0]    grant_id;
  logic [CW-1:0] total_cnt;
  logic [CW-1:0] accept_cnt;

  // Classifier: 010,101,111 -> 1 ; 000,011 -> 0
  logic [7:0] lut = 8'b1010_0100;
  assign class_result = lut[class_type];

  int n_run  = 0;
  int n_fail = 0;
  int cyc    = 0;
  int m_total;
  int m_accept;
  int last_cyc;
  int t_ack;

  blood_sample_scheduler #(
    .NUM_REQ(N),
    .CNT_W  (CW)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .req         (req),
    .req_type    (req_type),
    .ack         (ack),
    .result      (result),
    .class_type  (class_type),
    .class_result(class_result),
    .busy        (busy),
    .grant_id    (grant_id),
    .total_cnt   (total_cnt),
    .accept_cnt  (accept_cnt)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc = cyc + 1;

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_run++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    req      = '0;
    rst_n    = 1'b0;
    m_total  = 0;
    m_accept = 0;
    #7;
    rst_n    = 1'b1;
    tick();
  endtask

  function automatic logic [31:0] exp_cnt(input int m);
    return STATS ? 32'(m) : 32'd0;
  endfunction

  // Waits (bounded) for the next ack, then checks it.
  task automatic wait_ack(input int idx,
                          input logic [2:0] typ,
                          input string tag,
                          output int at);
    int k;
    logic r;
    k = 0;
    do begin
      tick();
      k++;
    end while (ack === '0 && k < 12);
    at = cyc;
    r  = lut[typ];
    check({tag, "_ack"}, 32'(ack), 32'(1) << idx);
    check({tag, "_res"}, 32'(result), 32'(r));
    check({tag, "_gid"}, 32'(grant_id), 32'(idx));
    if (m_total < CMAX) m_total++;
    if (r && m_accept < CMAX) m_accept++;
    check({tag, "_tot"}, 32'(total_cnt), exp_cnt(m_total));
    check({tag, "_acc"}, 32'(accept_cnt), exp_cnt(m_accept));
  endtask

  initial begin
    req      = '0;
    req_type = '0;
    rst_n    = 1'b0;
    m_total  = 0;
    m_accept = 0;
    #3;
    check("rst_ack",  32'(ack), 0);
    check("rst_res",  32'(result), 0);
    check("rst_ctyp", 32'(class_type), 0);
    check("rst_gid",  32'(grant_id), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_tot",  32'(total_cnt), 0);
    check("rst_acc",  32'(accept_cnt), 0);
    #4;
    rst_n = 1'b1;
    tick();

    // Single request, type 010
    req      = 4'b0001;
    req_type = 12'b000_000_000_010;
    tick();
    check("t1_ctyp", 32'(class_type), 32'b010);
    check("t1_busy", 32'(busy), 1);
    check("t1_ack0", 32'(ack), 0);
    tick();
    check("t1_ack",  32'(ack), 32'b0001);
    check("t1_res",  32'(result), 1);
    check("t1_tot",  32'(total_cnt), exp_cnt(1));
    req = '0;
    tick();
    check("t1_idle", 32'(busy), 0);
    check("t1_ackc", 32'(ack), 0);

    // All four continuously: 0,1,2,3,0 at 3-cycle spacing
    do_reset();
    req_type = {3'b111, 3'b101, 3'b011, 3'b000};
    req      = 4'b1111;
    for (int i = 0; i < 5; i++) begin
      wait_ack(i % 4, req_type[3*(i%4) +: 3], "t2", t_ack);
      if (i > 0)
        check("t2_gap", 32'(t_ack - last_cyc), 3);
      last_cyc = t_ack;
    end
    req = '0;
    tick();
    tick();

    // ptr=2, req=0011 -> station 0 then 1
    do_reset();
    req_type = {3'b000, 3'b000, 3'b101, 3'b011};
    req      = 4'b0010;
    wait_ack(1, 3'b101, "t3a", t_ack);
    req = 4'b0011;
    wait_ack(0, 3'b011, "t3b", t_ack);
    req = 4'b0010;
    wait_ack(1, 3'b101, "t3c", t_ack);
    req = '0;
    tick();
    tick();

    // Request dropped during EVAL still completes once
    do_reset();
    req_type = {3'b000, 3'b000, 3'b000, 3'b111};
    req      = 4'b0001;
    tick();
    req = '0;
    wait_ack(0, 3'b111, "t4", t_ack);
    tick();
    check("t4_ackc", 32'(ack), 0);
    tick();
    tick();
    check("t4_busy", 32'(busy), 0);
    check("t4_tot",  32'(total_cnt), exp_cnt(1));

    // Reset mid-EVAL aborts; restart from ptr=0
    req_type = {3'b101, 3'b000, 3'b000, 3'b010};
    req      = 4'b1001;
    tick();
    check("t5_gid3", 32'(grant_id), 3);
    rst_n    = 1'b0;
    m_total  = 0;
    m_accept = 0;
    tick();
    check("t5_ack",  32'(ack), 0);
    check("t5_busy", 32'(busy), 0);
    check("t5_gid",  32'(grant_id), 0);
    check("t5_tot",  32'(total_cnt), 0);
    check("t5_acc",  32'(accept_cnt), 0);
    rst_n = 1'b1;
    wait_ack(0, 3'b010, "t5a", t_ack);
    req = 4'b1000;
    wait_ack(3, 3'b101, "t5b", t_ack);
    req = '0;
    tick();
    tick();

    // Five accepts; counters saturate at 3
    do_reset();
    req_type = {3'b000, 3'b000, 3'b000, 3'b010};
    for (int i = 0; i < 5; i++) begin
      req = 4'b0001;
      wait_ack(0, 3'b010, "t6", t_ack);
      req = '0;
    end
    tick();
    tick();
    check("t6_tot", 32'(total_cnt),  STATS ? 32'd3 : 32'd0);
    check("t6_acc", 32'(accept_cnt), STATS ? 32'd3 : 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
